// File: rtl/board_io_pkg.sv
// board_io_pkg: board input/output widths, mask types and default rate constants
// shared by the button/switch reader and the LED driver.
package board_io_pkg;
   localparam int NUM_BTN          = 5;
   localparam int NUM_SW           = 8;
   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_STABLE_TICKS = 8;
   typedef logic [NUM_BTN-1:0] btn_mask_t;
   typedef logic [NUM_SW-1:0]  sw_mask_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: flips its level after STABLE_TICKS consecutive disagreeing ticks,
// with registered one-cycle rise/fall pulses aligned to the level change.
module debounce_bit #(
   parameter int STABLE_TICKS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic din_sync,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS) : 1;
   logic [CW-1:0] r_cnt;
   logic          r_level, r_rise, r_fall;
   logic          w_diff, w_flip;
   assign w_diff = din_sync ^ r_level;
   assign w_flip = tick && w_diff && (r_cnt == CW'(STABLE_TICKS - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_cnt   <= !tick ? r_cnt : (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
         r_level <= r_level ^ w_flip;
         r_rise  <= w_flip && din_sync;
         r_fall  <= w_flip && !din_sync;
      end
   end
   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;
endmodule

// File: rtl/btn_sw_reader.sv
// btn_sw_reader: synchronizes and debounces push-buttons and switches, emits edge
// pulses, and queues button-press masks behind a valid/ready handshake.
module btn_sw_reader
   import board_io_pkg::*;
#(
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  btn_mask_t btn,
   input  sw_mask_t  sw,
   output btn_mask_t btn_level,
   output btn_mask_t btn_press,
   output btn_mask_t btn_release,
   output sw_mask_t  sw_level,
   output logic      sw_change,
   output logic      evt_valid,
   output btn_mask_t evt_mask,
   input  logic      evt_ready,
   output logic      evt_ovf,
   input  logic      ovf_clr
);
   localparam int NB = NUM_BTN + NUM_SW;
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [NB-1:0] r_sync1, r_sync2;
   logic [NB-1:0] w_level, w_rise, w_fall;
   logic [PW-1:0] r_pre;
   logic          w_tick;
   btn_mask_t     r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wp, r_rp;
   logic          r_ovf;
   logic          w_empty, w_full, w_pop, w_push, w_drop;
   assign w_tick = r_pre == PW'(TICK_DIV - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_pre   <= '0;
      end else begin
         r_sync1 <= {sw, btn};
         r_sync2 <= r_sync1;
         r_pre   <= w_tick ? '0 : r_pre + 1'b1;
      end
   end
   for (genvar i = 0; i < NB; i++) begin : g_db
      debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
         .clk     (clk),
         .rst_n   (rst_n),
         .tick    (w_tick),
         .din_sync(r_sync2[i]),
         .level   (w_level[i]),
         .rise    (w_rise[i]),
         .fall    (w_fall[i])
      );
   end
   assign btn_level   = w_level[NUM_BTN-1:0];
   assign btn_press   = w_rise[NUM_BTN-1:0];
   assign btn_release = w_fall[NUM_BTN-1:0];
   assign sw_level    = w_level[NB-1:NUM_BTN];
   assign sw_change   = (|w_rise[NB-1:NUM_BTN]) | (|w_fall[NB-1:NUM_BTN]);
   // Extra wrap bit on the pointers distinguishes full from empty.
   assign w_empty = r_wp == r_rp;
   assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop   = !w_empty && evt_ready;
   assign w_push  = (|btn_press) && (!w_full || w_pop);
   assign w_drop  = (|btn_press) && w_full && !w_pop;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_mem[r_wp[AW-1:0]] <= btn_press;
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_ovf <= w_drop | (r_ovf & ~ovf_clr);
      end
   end
   assign evt_valid = !w_empty;
   assign evt_mask  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
   assign evt_ovf   = r_ovf;
endmodule

// File: tb/tb_btn_sw_reader.sv
// tb_btn_sw_reader: scenario tasks with a press-mask scoreboard queue for btn_sw_reader
// (TICK_DIV=4, STABLE_TICKS=3, FIFO_DEPTH=4).
module tb_btn_sw_reader;
   import board_io_pkg::*;
   logic      clk = 1'b0;
   logic      rst_n = 1'b1;
   btn_mask_t btn = '0;
   sw_mask_t  sw = '0;
   logic      evt_ready = 1'b0;
   logic      ovf_clr = 1'b0;
   btn_mask_t btn_level, btn_press, btn_release, evt_mask;
   sw_mask_t  sw_level;
   logic      sw_change, evt_valid, evt_ovf;
   int        cmp = 0;
   int        err = 0;
   btn_mask_t exp_q[$];

   always #5 clk = ~clk;

   btn_sw_reader #(.TICK_DIV(4), .STABLE_TICKS(3), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .sw_level(sw_level), .sw_change(sw_change),
      .evt_valid(evt_valid), .evt_mask(evt_mask), .evt_ready(evt_ready),
      .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
   );

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_press(input btn_mask_t m);
      btn = m;
      cycles(18);
      btn = '0;
      cycles(18);
   endtask

   task automatic pop_one(output btn_mask_t m, output bit ok);
      ok = 1'b0;
      m  = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (evt_valid) begin
            m = evt_mask;
            evt_ready = 1'b1;
            ok = 1'b1;
         end
      end
      @(posedge clk);
      #1 evt_ready = 1'b0;
   endtask

   task automatic test_reset;
      btn_mask_t m, e, pm;
      bit ok;
      int n_chg, n_press;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      btn = 5'h1F;
      sw  = 8'hFF;
      cycles(4);
      @(negedge clk);
      cmp++;
      if ({btn_level, btn_press, btn_release, sw_level, sw_change, evt_valid, evt_mask, evt_ovf} !== 31'd0) begin
         err++;
         $display("FAIL reset_outputs: got %h want 0",
                  {btn_level, btn_press, btn_release, sw_level, sw_change, evt_valid, evt_mask, evt_ovf});
      end
      exp_q.push_back(5'h1F);
      rst_n = 1'b1;
      n_chg = 0; n_press = 0; pm = '0;
      repeat (16) begin
         @(negedge clk);
         n_chg += int'(sw_change);
         if (btn_press != '0) begin n_press++; pm = btn_press; end
      end
      cmp++;
      if (sw_level !== 8'hFF) begin err++; $display("FAIL reset_sw_level: got %h want ff", sw_level); end
      cmp++;
      if (btn_level !== 5'h1F) begin err++; $display("FAIL reset_btn_level: got %h want 1f", btn_level); end
      cmp++;
      if (n_chg !== 1) begin err++; $display("FAIL reset_sw_change_count: got %0d want 1", n_chg); end
      cmp++;
      if (n_press !== 1 || pm !== 5'h1F) begin
         err++; $display("FAIL reset_press: got %0d pulses mask %h want 1 pulse mask 1f", n_press, pm);
      end
      pop_one(m, ok);
      e = exp_q.pop_front();
      cmp++;
      if (!ok || m !== e) begin err++; $display("FAIL reset_evt: got %h ok=%0d want %h", m, ok, e); end
      @(negedge clk);
      cmp++;
      if (evt_valid !== 1'b0) begin err++; $display("FAIL reset_evt_empty: got %b want 0", evt_valid); end
      btn = '0;
      sw  = '0;
      cycles(20);
      @(negedge clk);
      cmp++;
      if ({btn_level, sw_level} !== 13'd0) begin
         err++; $display("FAIL reset_release_levels: got %h want 0", {btn_level, sw_level});
      end
   endtask

   task automatic test_glitch;
      int n_bad;
      @(posedge clk);
      #1 btn = 5'h01;
      cycles(5);
      btn = '0;
      n_bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (btn_level != '0 || btn_press != '0 || evt_valid) n_bad++;
      end
      cmp++;
      if (n_bad !== 0) begin err++; $display("FAIL glitch: got %0d disturbed cycles want 0", n_bad); end
   endtask

   task automatic test_press_release;
      btn_mask_t m, e, pr;
      bit ok;
      int lat;
      btn = 5'h04;
      exp_q.push_back(5'h04);
      lat = 0; pr = '0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge clk);
         if (btn_level[2]) begin lat = i; pr = btn_press; end
      end
      cmp++;
      if (lat < 1 || lat > 15) begin err++; $display("FAIL press_latency: got %0d want 1..15", lat); end
      cmp++;
      if (pr !== 5'h04) begin err++; $display("FAIL press_pulse: got %h want 04", pr); end
      cycles(25);
      btn = '0;
      lat = 0; pr = '0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge clk);
         if (!btn_level[2]) begin lat = i; pr = btn_release; end
      end
      cmp++;
      if (lat < 1 || lat > 15) begin err++; $display("FAIL release_latency: got %0d want 1..15", lat); end
      cmp++;
      if (pr !== 5'h04) begin err++; $display("FAIL release_pulse: got %h want 04", pr); end
      pop_one(m, ok);
      e = exp_q.pop_front();
      cmp++;
      if (!ok || m !== e) begin err++; $display("FAIL press_evt: got %h ok=%0d want %h", m, ok, e); end
      @(negedge clk);
      cmp++;
      if (evt_valid !== 1'b0) begin err++; $display("FAIL press_single_entry: got valid %b want 0", evt_valid); end
   endtask

   task automatic test_simultaneous;
      btn_mask_t m, e, pm;
      bit ok;
      int n_press;
      @(posedge clk);
      #1 btn = 5'h0A;
      exp_q.push_back(5'h0A);
      n_press = 0; pm = '0;
      repeat (18) begin
         @(negedge clk);
         if (btn_press != '0) begin n_press++; pm = btn_press; end
      end
      cmp++;
      if (n_press !== 1 || pm !== 5'h0A) begin
         err++; $display("FAIL simul_press: got %0d pulses mask %h want 1 pulse mask 0a", n_press, pm);
      end
      btn = '0;
      cycles(18);
      pop_one(m, ok);
      e = exp_q.pop_front();
      cmp++;
      if (!ok || m !== e) begin err++; $display("FAIL simul_evt: got %h ok=%0d want %h", m, ok, e); end
      @(negedge clk);
      cmp++;
      if (evt_valid !== 1'b0) begin err++; $display("FAIL simul_single_entry: got valid %b want 0", evt_valid); end
   endtask

   task automatic test_overflow;
      btn_mask_t m, e;
      bit ok;
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         m = 5'(1 << i);
         if (i < 4) exp_q.push_back(m);
         do_press(m);
      end
      @(negedge clk);
      cmp++;
      if (evt_valid !== 1'b1) begin err++; $display("FAIL ovf_valid: got %b want 1", evt_valid); end
      cmp++;
      if (evt_ovf !== 1'b1) begin err++; $display("FAIL ovf_set: got %b want 1", evt_ovf); end
      @(posedge clk);
      #1 ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      @(negedge clk);
      cmp++;
      if (evt_ovf !== 1'b0) begin err++; $display("FAIL ovf_clear: got %b want 0", evt_ovf); end
      repeat (4) begin
         pop_one(m, ok);
         e = exp_q.pop_front();
         cmp++;
         if (!ok || m !== e) begin err++; $display("FAIL ovf_drain: got %h ok=%0d want %h", m, ok, e); end
      end
      @(negedge clk);
      cmp++;
      if (evt_valid !== 1'b0) begin err++; $display("FAIL ovf_empty: got valid %b want 0", evt_valid); end
   endtask

   task automatic test_full_pop;
      btn_mask_t m, e;
      bit ok, got;
      for (int i = 0; i < 4; i++) begin
         m = 5'(1 << i);
         exp_q.push_back(m);
         do_press(m);
      end
      btn = 5'h10;
      got = 1'b0;
      m = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (btn_press != '0) begin m = evt_mask; evt_ready = 1'b1; got = 1'b1; end
      end
      @(posedge clk);
      #1 evt_ready = 1'b0;
      e = exp_q.pop_front();
      exp_q.push_back(5'h10);
      cmp++;
      if (!got || m !== e) begin err++; $display("FAIL fullpop_head: got %h seen=%0d want %h", m, got, e); end
      btn = '0;
      cycles(18);
      @(negedge clk);
      cmp++;
      if (evt_ovf !== 1'b0) begin err++; $display("FAIL fullpop_ovf: got %b want 0", evt_ovf); end
      repeat (4) begin
         pop_one(m, ok);
         e = exp_q.pop_front();
         cmp++;
         if (!ok || m !== e) begin err++; $display("FAIL fullpop_drain: got %h ok=%0d want %h", m, ok, e); end
      end
      @(negedge clk);
      cmp++;
      if (evt_valid !== 1'b0) begin err++; $display("FAIL fullpop_empty: got valid %b want 0", evt_valid); end
   endtask

   initial begin
      test_reset;
      test_glitch;
      test_press_release;
      test_simultaneous;
      test_overflow;
      test_full_pop;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
